// File: rtl/count_rate_meter.sv
// count_rate_meter: receive-side companion of the switch-selectable tick
// generator. Measures the distance between rising edges of i_valid, decodes
// it back into the 2-bit rate code, and reports lock and strobe timeout.
module count_rate_meter #(
  parameter int NB_COUNTER = 32,
  parameter int NB_RATE    = 2
) (
  input  logic                  clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_tick,
  output logic [NB_COUNTER-1:0] o_period,
  output logic [NB_RATE-1:0]    o_rate,
  output logic                  o_match,
  output logic                  o_locked,
  output logic                  o_timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIRST = 2'd1,
    S_TRACK = 2'd2
  } state_e;

  localparam logic [NB_COUNTER-1:0] ONE     = {{(NB_COUNTER-1){1'b0}}, 1'b1};
  localparam logic [NB_COUNTER-1:0] P0      = ONE << (NB_COUNTER - 10);
  localparam logic [NB_COUNTER-1:0] P1      = ONE << (NB_COUNTER - 11);
  localparam logic [NB_COUNTER-1:0] P2      = ONE << (NB_COUNTER - 12);
  localparam logic [NB_COUNTER-1:0] P3      = ONE << (NB_COUNTER - 13);
  localparam logic [NB_COUNTER-1:0] TIMEOUT = ONE << (NB_COUNTER - 9);

  state_e                  state_q,   state_d;
  logic                    valid_q;
  logic [NB_COUNTER-1:0]   cnt_q,     cnt_d;
  logic                    tick_q,    tick_d;
  logic [NB_COUNTER-1:0]   period_q,  period_d;
  logic [NB_RATE-1:0]      rate_q,    rate_d;
  logic                    match_q,   match_d;
  logic                    locked_q,  locked_d;
  logic                    timeout_q, timeout_d;

  logic                    edge_det;
  logic                    at_timeout;
  logic                    dec_match;
  logic [NB_RATE-1:0]      dec_rate;

  assign edge_det   = i_valid & ~valid_q;
  assign at_timeout = (cnt_q == TIMEOUT);

  // Decode the running count against the four expected periods.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    dec_match = 1'b0;
    dec_rate  = rate_q;
    if (cnt_q == P0) begin
      dec_match = 1'b1;
      dec_rate  = NB_RATE'(0);
    end else if (cnt_q == P1) begin
      dec_match = 1'b1;
      dec_rate  = NB_RATE'(1);
    end else if (cnt_q == P2) begin
      dec_match = 1'b1;
      dec_rate  = NB_RATE'(2);
    end else if (cnt_q == P3) begin
      dec_match = 1'b1;
      dec_rate  = NB_RATE'(3);
    end
  end

  // Next-state and registered-output logic; an edge always beats a timeout.
  always_comb begin
    state_d   = state_q;
    tick_d    = 1'b0;
    timeout_d = 1'b0;
    period_d  = period_q;
    rate_d    = rate_q;
    match_d   = match_q;
    locked_d  = locked_q;
    unique case (state_q)
      S_IDLE: begin
        if (edge_det) begin
          tick_d  = 1'b1;
          state_d = S_FIRST;
        end
      end
      S_FIRST, S_TRACK: begin
        if (edge_det) begin
          tick_d   = 1'b1;
          period_d = cnt_q;
          match_d  = dec_match;
          rate_d   = dec_rate;
          locked_d = (state_q == S_TRACK) && dec_match && match_q && (dec_rate == rate_q);
          state_d  = S_TRACK;
        end else if (at_timeout) begin
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          match_d   = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Period counter: restarts at 1 on each edge, parks at 0 when idle, saturates at TIMEOUT.
  always_comb begin
    cnt_d = cnt_q;
    if (edge_det) begin
      cnt_d = ONE;
    end else if (state_q == S_IDLE || timeout_d) begin
      cnt_d = '0;
    end else if (!at_timeout) begin
      cnt_d = cnt_q + ONE;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge i_reset) begin
    // NOTE: asynchronous reset clears every flop; sequential state uses non-blocking assignments only.
    if (!i_reset) begin
      state_q   <= S_IDLE;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      period_q  <= '0;
      rate_q    <= '0;
      match_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= i_valid;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      period_q  <= period_d;
      rate_q    <= rate_d;
      match_q   <= match_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_tick    = tick_q;
  assign o_period  = period_q;
  assign o_rate    = rate_q;
  assign o_match   = match_q;
  assign o_locked  = locked_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_count_rate_meter.sv
// Testbench for count_rate_meter with NB_COUNTER=14 (periods 16/8/4/2, timeout 32).
// A gap-based reference model pushes expected ticks and timeouts into queues as
// stimulus is driven; a monitor pops and compares them when the DUT reports them.
module tb_count_rate_meter;

  localparam int NB      = 14;
  localparam int TIMEOUT = 32;

  typedef struct {
    int          cyc;
    logic [13:0] period;
    logic [1:0]  rate;
    logic        match;
    logic        locked;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          i_valid;
  logic          o_tick;
  logic [NB-1:0] o_period;
  logic [1:0]    o_rate;
  logic          o_match;
  logic          o_locked;
  logic          o_timeout;

  int   n_chk;
  int   n_bad;
  int   cyc;
  logic prev_v;

  int          m_state;  // 0 idle, 1 first, 2 track
  int          m_last;
  logic [13:0] m_period;
  logic [1:0]  m_rate;
  logic        m_match;
  logic        m_locked;

  exp_t eq[$];
  int   tq[$];

  count_rate_meter #(.NB_COUNTER(NB), .NB_RATE(2)) dut (
    .clock     (clk),
    .i_reset   (rst_n),
    .i_valid   (i_valid),
    .o_tick    (o_tick),
    .o_period  (o_period),
    .o_rate    (o_rate),
    .o_match   (o_match),
    .o_locked  (o_locked),
    .o_timeout (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_last   = 0;
    m_period = '0;
    m_rate   = '0;
    m_match  = 1'b0;
    m_locked = 1'b0;
  endtask

  // Reference behaviour for a detected rising edge at step cyc.
  task automatic model_edge();
    exp_t       e;
    int         g;
    logic       mt;
    logic [1:0] code;
    if (m_state == 0) begin
      m_state = 1;
    end else begin
      g    = cyc - m_last;
      mt   = 1'b1;
      code = m_rate;
      case (g)
        16:      code = 2'd0;
        8:       code = 2'd1;
        4:       code = 2'd2;
        2:       code = 2'd3;
        default: mt   = 1'b0;
      endcase
      m_locked = (m_state == 2) && mt && m_match && (code == m_rate);
      m_period = 14'(g);
      m_match  = mt;
      m_rate   = code;
      m_state  = 2;
    end
    m_last   = cyc;
    e.cyc    = cyc;
    e.period = m_period;
    e.rate   = m_rate;
    e.match  = m_match;
    e.locked = m_locked;
    eq.push_back(e);
  endtask

  // Drive one cycle of i_valid and advance the model.
  task automatic step(input logic v);
    logic is_edge;
    @(negedge clk);
    i_valid = v;
    cyc++;
    is_edge = v && !prev_v;
    prev_v  = v;
    if (is_edge) begin
      model_edge();
    end else if (m_state != 0 && (cyc - m_last) == TIMEOUT) begin
      tq.push_back(cyc);
      m_state  = 0;
      m_match  = 1'b0;
      m_locked = 1'b0;
    end
  endtask

  task automatic pulse(input int gap);
    step(1'b1);
    repeat (gap - 1) step(1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tick"},    o_tick,    0);
    check({tag, "_period"},  o_period,  0);
    check({tag, "_rate"},    o_rate,    0);
    check({tag, "_match"},   o_match,   0);
    check({tag, "_locked"},  o_locked,  0);
    check({tag, "_timeout"}, o_timeout, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    i_valid = 1'b0;
    prev_v  = 1'b0;
    #1;
    check_all_zero("midreset");
    check("midreset_pending_ticks", eq.size(), 0);
    eq.delete();
    tq.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: sample just after each rising edge and match DUT events to expectations.
  always @(posedge clk) begin : monitor
    exp_t e;
    int   tcyc;
    #1;
    if (o_tick) begin
      if (eq.size() == 0) begin
        check("unexpected_tick", 1, 0);
      end else begin
        e = eq.pop_front();
        check("tick_cycle", cyc, e.cyc);
        check("period",     o_period, e.period);
        check("rate",       o_rate,   e.rate);
        check("match",      o_match,  e.match);
        check("locked",     o_locked, e.locked);
      end
    end
    if (o_timeout) begin
      if (tq.size() == 0) begin
        check("unexpected_timeout", 1, 0);
      end else begin
        tcyc = tq.pop_front();
        check("timeout_cycle",  cyc,      tcyc);
        check("timeout_locked", o_locked, 0);
        check("timeout_match",  o_match,  0);
      end
    end
  end

  initial begin
    n_chk   = 0;
    n_bad   = 0;
    cyc     = 0;
    prev_v  = 1'b0;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    model_reset();

    #3;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(1'b0);

    // Rate 00 from reset: re-arm, measure, lock.
    repeat (4) pulse(16);
    // Every other rate code, including back-to-back toggling at P=2.
    repeat (6) pulse(8);
    repeat (6) pulse(4);
    repeat (6) pulse(2);
    // Non-matching period: rate held, no lock.
    repeat (3) pulse(10);
    // Re-lock at rate 00, then stuck-high strobe.
    repeat (3) pulse(16);
    step(1'b1);
    repeat (40) step(1'b1);
    repeat (3) step(1'b0);
    // After timeout the next pulse only re-arms.
    repeat (3) pulse(16);
    // Edge exactly at the timeout boundary.
    pulse(32);
    repeat (3) pulse(16);
    // Async reset mid-period while locked, then regain lock.
    step(1'b1);
    repeat (5) step(1'b0);
    do_reset();
    repeat (4) pulse(16);
    // Let the strobe stop; one final timeout.
    repeat (40) step(1'b0);
    repeat (2) @(negedge clk);

    check("leftover_ticks",    eq.size(), 0);
    check("leftover_timeouts", tq.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
